// File: rtl/seg_scanner_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment codes are {g,f,e,d,c,b,a} and active-low.
package seg_scanner_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } shadow_t;

  function automatic logic [3:0] an_select(input logic [1:0] idx);
    logic [3:0] an_v;
    case (idx)
      2'd0:    an_v = 4'b1110;
      2'd1:    an_v = 4'b1101;
      2'd2:    an_v = 4'b1011;
      2'd3:    an_v = 4'b0111;
      default: an_v = AN_OFF;
    endcase
    return an_v;
  endfunction

endpackage

// File: rtl/seg_scanner_hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_seg7
  import seg_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      4'hF:    seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scanner.sv
// Four-digit multiplexed display driver with per-frame input shadowing
// and an all-off guard interval at the start of every digit slot.
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 1000
) (
  input  logic        basys_clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);

  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  shadow_t          shadow_r;

  logic       frame_start_s;
  logic [0:0] state_s;
  logic       lit_s;
  logic [3:0] digit_s;
  logic [6:0] dec_s;
  logic [6:0] seg_nxt_s;
  logic [3:0] an_nxt_s;
  logic       dp_nxt_s;

  assign frame_start_s = (cnt_r == {CNT_W{1'b0}}) && (idx_r == 2'd0);
  assign state_s       = (cnt_r < GUARD_END) ? ST_GUARD : ST_SHOW;
  assign digit_s       = shadow_r.digits[{idx_r, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex (digit_s),
    .seg (dec_s)
  );

  // Slot counter and digit index
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 2'd0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Frame shadow: inputs only change the display at a frame boundary
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r <= '{digits: 16'h0000, blank: 4'h0, dp: 4'h0};
    end else if (frame_start_s) begin
      shadow_r <= '{digits: digits, blank: blank, dp: dp_in};
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Next output pattern; en is live so it bypasses the shadow
  always_comb begin
    lit_s     = 1'b0;
    seg_nxt_s = SEG_OFF;
    an_nxt_s  = AN_OFF;
    dp_nxt_s  = 1'b1;
    if ((state_s == ST_SHOW) && en && !shadow_r.blank[idx_r]) begin
      lit_s = 1'b1;
    end else begin
      lit_s = 1'b0;
    end
    if (lit_s) begin
      seg_nxt_s = dec_s;
      an_nxt_s  = an_select(idx_r);
      dp_nxt_s  = ~shadow_r.dp[idx_r];
    end else begin
      seg_nxt_s = SEG_OFF;
      an_nxt_s  = AN_OFF;
      dp_nxt_s  = 1'b1;
    end
  end

  // Registered pin drivers
  always_ff @(posedge basys_clk or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt_s;
      an         <= an_nxt_s;
      dp         <= dp_nxt_s;
      frame_tick <= frame_start_s;
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// Self-checking bench for seg_scanner at CLK_DIV=8, GUARD=2, against a
// frame-position model derived from the elapsed cycle count.
module tb_seg_scanner;

  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic        basys_clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  int          pos;
  logic [15:0] m_digits;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp;
  logic        exp_ft;
  logic [6:0]  dec_tab [16];
  logic [3:0]  an_tab  [4];
  logic [3:0]  prev_an;

  seg_scanner #(.CLK_DIV(DIV), .GUARD(GRD)) dut (
    .basys_clk  (basys_clk),
    .reset_n    (reset_n),
    .en         (en),
    .digits     (digits),
    .blank      (blank),
    .dp_in      (dp_in),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 basys_clk = ~basys_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s at pos %0d: got %h expected %h", tag, pos, obs, exp_v);
    end
  endtask

  // Reference: position in the frame follows from the cycle count alone
  task automatic model_edge();
    int c;
    int k;
    if (!reset_n) begin
      pos = 0;
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_ft = 1'b0;
      m_digits = 16'h0000; m_blank = 4'h0; m_dp = 4'h0;
    end else begin
      c = pos % DIV;
      k = (pos / DIV) % 4;
      exp_ft = ((pos % FRAME) == 0);
      if (exp_ft) begin
        m_digits = digits; m_blank = blank; m_dp = dp_in;
      end
      if (c < GRD || !en || m_blank[k]) begin
        exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
      end else begin
        exp_seg = dec_tab[(m_digits >> (4 * k)) & 16'hF];
        exp_an  = an_tab[k];
        exp_dp  = !m_dp[k];
      end
      pos++;
    end
  endtask

  task automatic tick();
    @(posedge basys_clk);
    model_edge();
    @(negedge basys_clk);
    chk("seg", {9'd0, seg}, {9'd0, exp_seg});
    chk("an", {12'd0, an}, {12'd0, exp_an});
    chk("dp", {15'd0, dp}, {15'd0, exp_dp});
    chk("frame_tick", {15'd0, frame_tick}, {15'd0, exp_ft});
    chk("one_anode", {15'd0, ($countones(~an) <= 1)}, 16'd1);
    chk("anode_switch", {15'd0, (an == 4'hF || prev_an == 4'hF || an == prev_an)}, 16'd1);
    prev_an = an;
  endtask

  task automatic run_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic run_to_phase(input int ph);
    int t;
    t = pos + ((ph - (pos % FRAME) + FRAME) % FRAME);
    if (t == pos) t = t + FRAME;
    run_to(t);
  endtask

  initial begin
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001; dec_tab[2]  = 7'b0100100;
    dec_tab[3]  = 7'b0110000; dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000; dec_tab[8]  = 7'b0000000;
    dec_tab[9]  = 7'b0010000; dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001; dec_tab[14] = 7'b0000110;
    dec_tab[15] = 7'b0001110;
    an_tab[0] = 4'hE; an_tab[1] = 4'hD; an_tab[2] = 4'hB; an_tab[3] = 4'h7;
    prev_an = 4'hF;
    pos = 0;
    reset_n = 1'b0; en = 1'b1; digits = 16'h3A81; blank = 4'h0; dp_in = 4'h0;

    repeat (3) tick();
    reset_n = 1'b1;

    tick();
    chk("release_ft", {15'd0, frame_tick}, 16'd1);
    chk("guard_an_1", {12'd0, an}, 16'h000F);
    tick();
    chk("guard_an_2", {12'd0, an}, 16'h000F);
    tick();
    chk("digit0_an", {12'd0, an}, 16'h000E);
    chk("digit0_seg", {9'd0, seg}, 16'b1111001);

    run_to(18);
    digits = 16'hFFFF;
    run_to(27);
    chk("tear_digit3", {9'd0, seg}, 16'b0110000);
    run_to(35);
    chk("next_frame_F", {9'd0, seg}, 16'b0001110);

    run_to_phase(30);
    blank = 4'b0100; dp_in = 4'b0001; digits = 16'h5C27;
    run_to_phase(4);
    chk("dp_digit0", {15'd0, dp}, 16'd0);
    run_to_phase(21);
    chk("blank_an", {12'd0, an}, 16'h000F);
    run_to_phase(0);

    run_to_phase(13);
    en = 1'b0;
    tick();
    chk("en_off_an", {12'd0, an}, 16'h000F);
    tick();
    en = 1'b1;
    tick();
    chk("en_back_an", {12'd0, an}, 16'h000D);
    run_to_phase(0);

    repeat (400) begin
      if ($urandom_range(0, 7) == 0) begin
        digits = 16'($urandom());
        blank  = 4'($urandom_range(0, 15));
        dp_in  = 4'($urandom_range(0, 15));
        en     = ($urandom_range(0, 5) != 0);
      end
      tick();
    end
    en = 1'b1; blank = 4'h0; digits = 16'hBEEF;

    run_to_phase(0);
    run_to_phase(28);
    reset_n = 1'b0;
    #1;
    chk("async_seg", {9'd0, seg}, 16'h007F);
    chk("async_an", {12'd0, an}, 16'h000F);
    chk("async_dp", {15'd0, dp}, 16'd1);
    chk("async_ft", {15'd0, frame_tick}, 16'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("restart_ft", {15'd0, frame_tick}, 16'd1);
    repeat (3) tick();
    chk("restart_an", {12'd0, an}, 16'h000E);
    run_to(2 * FRAME + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
